// File: rtl/delay_pkg.sv
// -----------------------------------------------------------------------------
// delay_pkg
// Shared definitions for the delay_monitor pulse-period checker:
//   - state_t       : monitor FSM states
//   - DEF_*         : default nominal period, counter width, tolerance, lock count
//   - in_window()   : cnt inside [n-tol, n+tol]
//   - is_early()    : cnt below n-tol
// Configuration macro used by the monitor: DELAY_MONITOR_STATS_EN
// -----------------------------------------------------------------------------
package delay_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACQ   = 2'd1,
        ST_LOCK  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam int DEF_N        = 12500;
    localparam int DEF_CBITS    = 14;
    localparam int DEF_TOL      = 2;
    localparam int DEF_LOCK_CNT = 3;

    // Written as cnt + tol >= n so the lower bound never underflows.
    function automatic logic in_window(input int unsigned cnt,
                                       input int unsigned n,
                                       input int unsigned tol);
        return ((cnt + tol) >= n) && (cnt <= (n + tol));
    endfunction

    function automatic logic is_early(input int unsigned cnt,
                                      input int unsigned n,
                                      input int unsigned tol);
        return (cnt + tol) < n;
    endfunction

endpackage

// File: rtl/delay_interval_ctr.sv
// -----------------------------------------------------------------------------
// delay_interval_ctr
// Counts cycles since the last sampled pulse and classifies the count.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   sig_i      : pulse input; a sampled 1 clears the counter
//   cnt_o      : current count (saturates at all-ones)
//   in_win_o   : cnt within [N-TOL, N+TOL]
//   early_o    : cnt below N-TOL
//   late_o     : cnt equals N+TOL+1 (first count past the window)
// -----------------------------------------------------------------------------
module delay_interval_ctr
    import delay_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int CBITS = DEF_CBITS,
    parameter int TOL   = DEF_TOL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_i,
    output logic [CBITS-1:0] cnt_o,
    output logic             in_win_o,
    output logic             early_o,
    output logic             late_o
);

    localparam logic [CBITS-1:0] CNT_MAX = '1;
    localparam logic [CBITS-1:0] LATE_AT = CBITS'(N + TOL + 1);

    logic [CBITS-1:0] cnt_q;
    logic [CBITS-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (sig_i) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CBITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign in_win_o = in_window(32'(cnt_q), N, TOL);
    assign early_o  = is_early(32'(cnt_q), N, TOL);
    // The count passes LATE_AT exactly once per interval (it saturates well
    // above it), so this equality gives a single late event per interval. It
    // also flags a pulse arriving on exactly that count as late, since no
    // late event has fired for that interval yet.
    assign late_o   = (cnt_q == LATE_AT);

endmodule

// File: rtl/delay_monitor.sv
// -----------------------------------------------------------------------------
// delay_monitor
// Checks that sig pulses arrive every N+1 cycles (+/- TOL), locks after
// LOCK_CNT consecutive good intervals and reports early/late intervals.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   sig         : periodic pulse under test
//   lock        : period locked
//   err_early   : one-cycle pulse, interval too short
//   err_late    : one-cycle pulse, interval too long or pulse missing
//   flg         : count inside the acceptance window (not in IDLE)
//   period      : last measured interval
//   period_vld  : one-cycle pulse, period updated
//   err_count   : saturating error count
// Optional feature: define DELAY_MONITOR_STATS_EN to enable err_count;
// otherwise err_count is tied to 0.
// -----------------------------------------------------------------------------
module delay_monitor
    import delay_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int CBITS    = DEF_CBITS,
    parameter int TOL      = DEF_TOL,
    parameter int LOCK_CNT = DEF_LOCK_CNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig,
    output logic             lock,
    output logic             err_early,
    output logic             err_late,
    output logic             flg,
    output logic [CBITS-1:0] period,
    output logic             period_vld,
    output logic [15:0]      err_count
);

    localparam int GW = $clog2(LOCK_CNT + 1);

    // Parameter sanity: the late point must be reachable before saturation.
    if ((N + TOL + 1) >= (2 ** CBITS)) begin : g_bad_cbits
        $error("delay_monitor: N+TOL+1 must be below 2**CBITS");
    end
    if (TOL > N) begin : g_bad_tol
        $error("delay_monitor: TOL must not exceed N");
    end
    if (LOCK_CNT < 1) begin : g_bad_lock
        $error("delay_monitor: LOCK_CNT must be at least 1");
    end

    logic [CBITS-1:0] cnt;
    logic             in_win;
    logic             early;
    logic             late_evt;

    delay_interval_ctr #(
        .N     (N),
        .CBITS (CBITS),
        .TOL   (TOL)
    ) u_ctr (
        .clk      (clk),
        .rst      (rst),
        .sig_i    (sig),
        .cnt_o    (cnt),
        .in_win_o (in_win),
        .early_o  (early),
        .late_o   (late_evt)
    );

    state_t           state_q, state_d;
    logic [GW-1:0]    good_cnt_q, good_cnt_d;
    logic             lock_q, lock_d;
    logic             err_early_q, err_early_d;
    logic             err_late_q, err_late_d;
    logic             flg_q, flg_d;
    logic [CBITS-1:0] period_q, period_d;
    logic             period_vld_q, period_vld_d;

    logic active;
    assign active = (state_q != ST_IDLE);

    always_comb begin
        state_d      = state_q;
        good_cnt_d   = good_cnt_q;
        err_early_d  = 1'b0;
        err_late_d   = 1'b0;
        period_d     = period_q;
        period_vld_d = 1'b0;
        flg_d        = active && in_win;

        if (active && sig) begin
            period_d     = cnt + CBITS'(1);
            period_vld_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (sig) begin
                    state_d    = ST_ACQ;
                    good_cnt_d = '0;
                end
            end
            ST_ACQ: begin
                // Late takes priority: a pulse on the late count is one
                // late error, and the counter restarts on that pulse.
                if (late_evt) begin
                    err_late_d = 1'b1;
                    good_cnt_d = '0;
                end else if (sig) begin
                    if (early) begin
                        err_early_d = 1'b1;
                        good_cnt_d  = '0;
                    end else if (in_win) begin
                        good_cnt_d = good_cnt_q + GW'(1);
                        if (good_cnt_d == GW'(LOCK_CNT)) begin
                            state_d = ST_LOCK;
                        end
                    end
                end
            end
            ST_LOCK: begin
                if (late_evt) begin
                    err_late_d = 1'b1;
                    state_d    = ST_FAULT;
                end else if (sig && early) begin
                    err_early_d = 1'b1;
                    state_d     = ST_FAULT;
                end
            end
            ST_FAULT: begin
                if (late_evt) begin
                    err_late_d = 1'b1;
                end else if (sig && early) begin
                    err_early_d = 1'b1;
                end
                if (sig) begin
                    state_d    = ST_ACQ;
                    good_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                good_cnt_d = '0;
            end
        endcase

        lock_d = (state_d == ST_LOCK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            good_cnt_q   <= '0;
            lock_q       <= 1'b0;
            err_early_q  <= 1'b0;
            err_late_q   <= 1'b0;
            flg_q        <= 1'b0;
            period_q     <= '0;
            period_vld_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            good_cnt_q   <= good_cnt_d;
            lock_q       <= lock_d;
            err_early_q  <= err_early_d;
            err_late_q   <= err_late_d;
            flg_q        <= flg_d;
            period_q     <= period_d;
            period_vld_q <= period_vld_d;
        end
    end

    assign lock       = lock_q;
    assign err_early  = err_early_q;
    assign err_late   = err_late_q;
    assign flg        = flg_q;
    assign period     = period_q;
    assign period_vld = period_vld_q;

`ifdef DELAY_MONITOR_STATS_EN
    logic [15:0] err_count_q, err_count_d;

    // Counts in step with the error pulses, so the new count appears in
    // the same cycle as the pulse it includes.
    always_comb begin
        err_count_d = err_count_q;
        if ((err_early_d || err_late_d) && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`else
    assign err_count = 16'd0;
`endif

endmodule

// File: tb/tb_delay_monitor.sv
// -----------------------------------------------------------------------------
// tb_delay_monitor
// Directed stimulus for delay_monitor with N=10, TOL=1, LOCK_CNT=3 (nominal
// interval 11). An interval-based reference model predicts every output
// each cycle; literal expectations pin the key scenarios.
// -----------------------------------------------------------------------------
module tb_delay_monitor;

    localparam int N     = 10;
    localparam int CB    = 14;
    localparam int TOL   = 1;
    localparam int LC    = 3;
    localparam int SMAX  = (1 << CB) - 1;
`ifdef DELAY_MONITOR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_ACQ   = 1;
    localparam int M_LOCK  = 2;
    localparam int M_FAULT = 3;

    logic          clk;
    logic          rst;
    logic          sig;
    logic          lock;
    logic          err_early;
    logic          err_late;
    logic          flg;
    logic [CB-1:0] period;
    logic          period_vld;
    logic [15:0]   err_count;

    int checks = 0;
    int errors = 0;

    // reference model state
    int      m_since;     // zero samples since the last pulse
    int      m_mode;
    int      m_good;
    bit      m_late_done; // late already reported in this interval
    bit      e_lock, e_early, e_late, e_flg, e_vld;
    int      e_period;
    int      e_count;

    delay_monitor #(
        .N        (N),
        .CBITS    (CB),
        .TOL      (TOL),
        .LOCK_CNT (LC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sig        (sig),
        .lock       (lock),
        .err_early  (err_early),
        .err_late   (err_late),
        .flg        (flg),
        .period     (period),
        .period_vld (period_vld),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs after one clock edge, from interval arithmetic.
    task automatic model_step(input logic s, input logic r);
        int  ivl;
        bit  act, lt, er, gd;
        if (r) begin
            m_since = 0; m_mode = M_IDLE; m_good = 0; m_late_done = 0;
            e_lock = 0; e_early = 0; e_late = 0; e_flg = 0; e_vld = 0;
            e_period = 0; e_count = 0;
            return;
        end
        ivl = m_since + 1;
        act = (m_mode != M_IDLE);
        lt  = act && !m_late_done && (m_since > N + TOL);
        er  = act && s && !lt && (ivl <= N - TOL);
        gd  = s && !lt && (ivl >= N - TOL + 1) && (ivl <= N + TOL + 1);
        e_flg   = act && (m_since >= N - TOL) && (m_since <= N + TOL);
        e_vld   = act && s;
        if (e_vld) e_period = ivl % (SMAX + 1);
        e_early = er;
        e_late  = lt;
        if (STATS && (er || lt) && e_count < 65535) e_count++;
        case (m_mode)
            M_IDLE:  if (s) begin m_mode = M_ACQ; m_good = 0; end
            M_ACQ: begin
                if (er || lt) m_good = 0;
                else if (gd) begin
                    m_good++;
                    if (m_good == LC) m_mode = M_LOCK;
                end
            end
            M_LOCK:  if (er || lt) m_mode = M_FAULT;
            default: if (s) begin m_mode = M_ACQ; m_good = 0; end
        endcase
        e_lock = (m_mode == M_LOCK);
        if (lt) m_late_done = 1;
        if (s) begin
            m_since = 0;
            m_late_done = 0;
        end else if (m_since < SMAX) begin
            m_since++;
        end
    endtask

    task automatic compare_all();
        chk("lock",       32'(lock),       32'(e_lock));
        chk("err_early",  32'(err_early),  32'(e_early));
        chk("err_late",   32'(err_late),   32'(e_late));
        chk("flg",        32'(flg),        32'(e_flg));
        chk("period_vld", 32'(period_vld), 32'(e_vld));
        chk("period",     32'(period),     32'(e_period));
        chk("err_count",  32'(err_count),  32'(e_count));
    endtask

    task automatic cyc(input logic s, input logic r);
        @(negedge clk);
        sig = s;
        rst = r;
        @(posedge clk);
        model_step(s, r);
        #1;
        compare_all();
    endtask

    // One interval of len cycles: len-1 idle samples then a pulse.
    task automatic interval(input int len);
        for (int i = 0; i < len - 1; i++) cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        $display("interval %0d: lock=%0b period=%0d vld=%0b early=%0b late=%0b count=%0d",
                 len, lock, period, period_vld, err_early, err_late, err_count);
    endtask

    initial begin
        int late_n, late_at, flg_n, flg_first;
        sig = 1'b0;
        rst = 1'b1;
        model_step(1'b0, 1'b1);

        // reset state
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
        chk("rst_lock",   32'(lock),       0);
        chk("rst_period", 32'(period),     0);
        chk("rst_count",  32'(err_count),  0);

        // acquisition from reset at the nominal interval
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        chk("first_vld", 32'(period_vld), 0);
        interval(11);
        chk("p2_period", 32'(period), 11);
        chk("p2_vld",    32'(period_vld), 1);
        chk("p2_lock",   32'(lock), 0);
        interval(11);
        interval(11);
        chk("p4_lock",   32'(lock), 1);
        chk("p4_period", 32'(period), 11);
        interval(11);

        // early pulse while locked
        interval(8);
        chk("early_pulse", 32'(err_early), 1);
        chk("early_lock",  32'(lock), 0);
        chk("early_count", 32'(err_count), STATS ? 1 : 0);

        // recover: FAULT -> ACQ, then three good intervals
        interval(11);
        interval(11);
        interval(11);
        interval(11);
        chk("relock1", 32'(lock), 1);

        // pulse withheld while locked
        late_n = 0; late_at = 0; flg_n = 0; flg_first = 0;
        for (int j = 1; j <= 20; j++) begin
            cyc(1'b0, 1'b0);
            if (err_late) begin late_n++; late_at = j; end
            if (flg) begin
                if (flg_n == 0) flg_first = j;
                flg_n++;
            end
        end
        $display("withheld: late pulses=%0d at=%0d flg cycles=%0d first=%0d", late_n, late_at, flg_n, flg_first);
        chk("late_once",  32'(late_n), 1);
        chk("late_at",    32'(late_at), 13);
        chk("flg_cycles", 32'(flg_n), 3);
        chk("flg_first",  32'(flg_first), 10);
        chk("late_lock",  32'(lock), 0);
        chk("late_count", 32'(err_count), STATS ? 2 : 0);
        interval(1);  // pulse after long gap: FAULT -> ACQ, no extra error
        chk("gap_early", 32'(err_early), 0);

        // window edges 10/12/11 all good
        interval(10);
        interval(12);
        chk("edge_lock_pre", 32'(lock), 0);
        interval(11);
        chk("edge_lock", 32'(lock), 1);
        interval(9);
        chk("ivl9_early", 32'(err_early), 1);
        chk("ivl9_lock",  32'(lock), 0);
        interval(11);
        interval(11);
        interval(11);
        interval(11);
        chk("relock2", 32'(lock), 1);
        interval(13);
        chk("ivl13_late",  32'(err_late), 1);
        chk("ivl13_early", 32'(err_early), 0);
        chk("ivl13_lock",  32'(lock), 0);

        // reset in LOCK mid-interval, colliding with a pulse
        interval(11);
        interval(11);
        interval(11);
        interval(11);
        chk("relock3", 32'(lock), 1);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b1);
        chk("rstlk_lock", 32'(lock), 0);
        chk("rstlk_flg",  32'(flg), 0);
        chk("rstlk_vld",  32'(period_vld), 0);
        chk("rstlk_per",  32'(period), 0);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        chk("rstlk_first", 32'(period_vld), 0);
        interval(11);
        interval(11);
        interval(11);
        chk("rstlk_relock", 32'(lock), 1);

        // sig held high: every extra cycle is an early pulse
        for (int i = 0; i < 70000; i++) cyc(1'b1, 1'b0);
        $display("held high 70000 cycles: count=%0d early=%0b", err_count, err_early);
        chk("hold_early", 32'(err_early), 1);
        chk("hold_sat",   32'(err_count), STATS ? 32'hFFFF : 0);
        chk("hold_vld",   32'(period), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
